// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP CPU port controller: port encodings, FSM states,
// status/control bit positions and register indices.
package vdp_pkg;

    localparam logic PORT_DATA = 1'b0;  // 0x98
    localparam logic PORT_CTRL = 1'b1;  // 0x99

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_ACC  = 2'd2
    } vdp_state_e;

    localparam int STAT_F_BIT    = 7;
    localparam int CTRL_REG_BIT  = 7;  // second control byte: 1 = register write
    localparam int CTRL_NOPF_BIT = 6;  // second control byte: 1 = address setup without prefetch

    localparam int         NUM_REGS     = 8;
    localparam logic [2:0] REG_MODE1    = 3'd1;
    localparam int         MODE1_IE_BIT = 5;

    function automatic logic [7:0] status_byte(input logic f);
        status_byte = 8'h00;
        status_byte[STAT_F_BIT] = f;
    endfunction

endpackage

// File: rtl/vdp_vram_arb.sv
// VRAM port arbiter: video has priority, but a CPU access that has waited
// STARVE_MAX cycles takes the port on the following cycle regardless.
module vdp_vram_arb #(
    parameter int STARVE_MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_req,
    input  logic vid_req,
    output logic cpu_grant,
    output logic vid_valid
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;
    logic          starved;
    logic          vid_grant;

    assign starved   = (starve_cnt >= CW'(STARVE_MAX));
    assign cpu_grant = cpu_req && (!vid_req || starved);
    assign vid_grant = vid_req && !cpu_grant;

    // Counts waiting cycles; a grant moves the FSM into ACC, which restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (cpu_grant) begin
            starve_cnt <= '0;
        end else if (cpu_req && !starved) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vid_valid <= 1'b0;
        end else begin
            vid_valid <= vid_grant;
        end
    end

endmodule

// File: rtl/vdp_port_ctrl.sv
// CPU-side port controller of a TMS9918-style VDP: control latch, address pointer,
// registers, status flag and the VRAM access FSM. Optional macro VDP_READ_AHEAD_EN
// enables the read-ahead buffer; without it data reads stall until the byte arrives.
module vdp_port_ctrl
    import vdp_pkg::*;
#(
    parameter int VRAM_AW    = 14,
    parameter int STARVE_MAX = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               io_wr,
    input  logic               io_rd,
    input  logic               io_port,
    input  logic [7:0]         io_din,
    output logic [7:0]         io_dout,
    output logic               cpu_wait,
    input  logic               vblank,
    output logic               n_int,
    input  logic               vid_req,
    input  logic [VRAM_AW-1:0] vid_addr,
    output logic               vid_valid,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic               vram_we,
    output logic [7:0]         vram_wdata,
    input  logic [7:0]         vram_rdata,
    output logic [63:0]        vdp_regs,
    output vdp_state_e         dbg_state
);

    // Handshake: io_wr/io_rd are one-cycle strobes accepted only while cpu_wait is low;
    // cpu_wait stays high from the cycle after a queuing strobe until the access leaves ACC.

    vdp_state_e         state, state_nxt;
    logic [VRAM_AW-1:0] ptr, ptr_inc, setup_ptr;
    logic [13:0]        setup_full;
    logic [VRAM_AW-1:0] pend_addr;
    logic               pend_we;
    logic [7:0]         pend_data;
    logic               toggle;
    logic [7:0]         latch;
    logic [7:0]         regs [NUM_REGS];
    logic [7:0]         rd_buf;
    logic               f_flag;
    logic               cpu_grant;

    logic               data_wr, data_rd, ctrl_wr, ctrl_rd;
    logic               second_byte, setup_addr, setup_reg;
    logic               q_req, q_we;
    logic [VRAM_AW-1:0] q_addr;

    vdp_vram_arb #(
        .STARVE_MAX(STARVE_MAX)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .cpu_req  (state == ST_PEND),
        .vid_req  (vid_req),
        .cpu_grant(cpu_grant),
        .vid_valid(vid_valid)
    );

    always_comb begin
        data_wr     = io_wr && (io_port == PORT_DATA);
        data_rd     = io_rd && (io_port == PORT_DATA);
        ctrl_wr     = io_wr && (io_port == PORT_CTRL);
        ctrl_rd     = io_rd && (io_port == PORT_CTRL);
        setup_full  = {io_din[5:0], latch};
        setup_ptr   = VRAM_AW'(setup_full);
        ptr_inc     = ptr + VRAM_AW'(1);
        second_byte = ctrl_wr && toggle;
        setup_addr  = second_byte && !io_din[CTRL_REG_BIT];
        setup_reg   = second_byte && io_din[CTRL_REG_BIT] && (io_din[5:3] == 3'b000);
    end

    // Access request raised by the current strobe, if any.
    always_comb begin
        q_req  = 1'b0;
        q_we   = 1'b0;
        q_addr = ptr;
        if (data_wr) begin
            q_req  = 1'b1;
            q_we   = 1'b1;
            q_addr = ptr;
        end else if (data_rd) begin
            q_req  = 1'b1;
`ifdef VDP_READ_AHEAD_EN
            q_addr = ptr_inc;
`else
            q_addr = ptr;
`endif
        end
`ifdef VDP_READ_AHEAD_EN
        else if (setup_addr && !io_din[CTRL_NOPF_BIT]) begin
            q_req  = 1'b1;
            q_addr = setup_ptr;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (q_req) state_nxt = ST_PEND;
            ST_PEND: if (cpu_grant) state_nxt = ST_ACC;
            ST_ACC:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            pend_addr <= '0;
            pend_we   <= 1'b0;
            pend_data <= 8'h00;
            toggle    <= 1'b0;
            latch     <= 8'h00;
            rd_buf    <= 8'h00;
            f_flag    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            if (state == ST_IDLE && q_req) begin
                pend_addr <= q_addr;
                pend_we   <= q_we;
                pend_data <= io_din;
            end
            // vram_rdata carries the byte addressed in the grant cycle.
            if (state == ST_ACC && !pend_we) begin
                rd_buf <= vram_rdata;
            end
            if (ctrl_wr) begin
                if (!toggle) begin
                    latch  <= io_din;
                    toggle <= 1'b1;
                end else begin
                    toggle <= 1'b0;
                    if (setup_addr) ptr <= setup_ptr;
                    if (setup_reg) regs[io_din[2:0]] <= latch;
                end
            end
            if (data_wr || data_rd || ctrl_rd) toggle <= 1'b0;
            if (data_wr || data_rd) ptr <= ptr_inc;
            // A frame end in the same cycle as a status read wins so the event is not lost.
            if (vblank) begin
                f_flag <= 1'b1;
            end else if (ctrl_rd) begin
                f_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            vdp_regs[8*i +: 8] = regs[i];
        end
    end

    assign io_dout    = ctrl_rd ? status_byte(f_flag) : rd_buf;
    assign cpu_wait   = (state != ST_IDLE);
    assign n_int      = !(f_flag && regs[REG_MODE1][MODE1_IE_BIT]);
    assign vram_we    = cpu_grant && pend_we;
    assign vram_addr  = cpu_grant ? pend_addr : vid_addr;
    assign vram_wdata = pend_data;
    assign dbg_state  = state;

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Bench for vdp_port_ctrl: owns the VRAM array and a byte-level model of the
// pointer, latch, registers, status flag and read buffer.
`timescale 1ns/1ps
module tb_vdp_port_ctrl;
    import vdp_pkg::*;

    localparam int AW    = 14;
    localparam int DEPTH = 1 << AW;
    localparam int SMAX  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          io_wr = 1'b0, io_rd = 1'b0, io_port = 1'b0;
    logic [7:0]    io_din = 8'h00;
    logic [7:0]    io_dout;
    logic          cpu_wait;
    logic          vblank = 1'b0;
    logic          n_int;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_valid;
    logic [AW-1:0] vram_addr;
    logic          vram_we;
    logic [7:0]    vram_wdata;
    logic [7:0]    vram_rdata = 8'h00;
    logic [63:0]   vdp_regs;
    vdp_state_e    dbg_state;

    int vectors = 0, miscompares = 0, we_count = 0;
    bit vid_rand = 1'b0, vid_force = 1'b0;

    logic [7:0]    mem    [DEPTH];
    logic [7:0]    shadow [DEPTH];
    int            m_ptr;
    bit            m_toggle;
    logic [7:0]    m_latch;
    logic [7:0]    m_regs [8];
    bit            m_f;
    logic [7:0]    m_buf;
    logic [AW-1:0] wr_addr_q [$];
    logic [7:0]    exp_q [$];
    logic          p_req = 1'b0;
    logic [AW-1:0] p_addr = '0;

    vdp_port_ctrl #(.VRAM_AW(AW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset), .io_wr(io_wr), .io_rd(io_rd), .io_port(io_port),
        .io_din(io_din), .io_dout(io_dout), .cpu_wait(cpu_wait), .vblank(vblank),
        .n_int(n_int), .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid),
        .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
        .vram_rdata(vram_rdata), .vdp_regs(vdp_regs), .dbg_state(dbg_state)
    );

    // ---------------- clock / VRAM / video side ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vram_we === 1'b1) begin
            mem[vram_addr] <= vram_wdata;
            we_count++;
        end
        vram_rdata <= mem[vram_addr];
        p_req  <= vid_req;
        p_addr <= vid_addr;
    end

    always @(negedge clk) begin
        if (vid_force) vid_req = 1'b1;
        else if (vid_rand) vid_req = ($urandom_range(0, 3) != 0);
        else vid_req = 1'b0;
        vid_addr = AW'($urandom_range(0, DEPTH - 1));
    end

    // Every vid_valid must follow a request and carry the requested byte.
    always @(negedge clk) begin
        if (vid_valid === 1'b1) begin
            vectors++;
            if (p_req !== 1'b1 || vram_rdata !== mem[p_addr]) begin
                miscompares++;
                $display("FAIL vid_valid: req=%b rdata=%h required req=1 rdata=%h", p_req, vram_rdata, mem[p_addr]);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic void model_reset();
        m_ptr = 0; m_toggle = 0; m_latch = 8'h00; m_f = 0; m_buf = 8'h00;
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    endfunction

    function automatic void model_ctrl_write(input logic [7:0] d);
        if (!m_toggle) begin
            m_latch = d; m_toggle = 1;
        end else begin
            m_toggle = 0;
            if (!d[7]) begin
                m_ptr = int'({d[5:0], m_latch}) % DEPTH;
`ifdef VDP_READ_AHEAD_EN
                if (!d[6]) m_buf = shadow[m_ptr];
`endif
            end else if (d[5:3] == 3'b000) begin
                m_regs[d[2:0]] = m_latch;
            end
        end
    endfunction

    function automatic void model_data_write(input logic [7:0] d);
        shadow[m_ptr] = d;
        wr_addr_q.push_back(AW'(m_ptr));
        m_toggle = 0;
        m_ptr = (m_ptr + 1) % DEPTH;
    endfunction

    function automatic logic [7:0] model_data_read();
        logic [7:0] r;
`ifdef VDP_READ_AHEAD_EN
        r = m_buf;
        m_ptr = (m_ptr + 1) % DEPTH;
        m_buf = shadow[m_ptr];
`else
        r = shadow[m_ptr];
        m_ptr = (m_ptr + 1) % DEPTH;
`endif
        m_toggle = 0;
        return r;
    endfunction

    function automatic logic [7:0] model_status_read(input bit vb);
        logic [7:0] r;
        r = m_f ? 8'h80 : 8'h00;
        m_f = vb;
        m_toggle = 0;
        return r;
    endfunction

    function automatic logic [63:0] model_regs();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = m_regs[i];
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        #1;
        while (cpu_wait !== 1'b0 && n < 100) begin
            @(negedge clk); #1; n++;
        end
        vectors++;
        if (cpu_wait !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_idle: cpu_wait=%b required 0 within 100 cycles", tag, cpu_wait);
        end
    endtask

    task automatic io_write(input logic port, input logic [7:0] data);
        @(negedge clk);
        io_port = port; io_din = data; io_wr = 1'b1;
        if (port == PORT_DATA) model_data_write(data);
        else model_ctrl_write(data);
        @(negedge clk);
        io_wr = 1'b0;
        wait_idle("io_write");
    endtask

    task automatic io_read_data(output logic [7:0] got);
`ifdef VDP_READ_AHEAD_EN
        @(negedge clk);
        io_port = PORT_DATA; io_rd = 1'b1;
        #1 got = io_dout;
        @(negedge clk);
        io_rd = 1'b0;
        wait_idle("io_read");
`else
        @(negedge clk);
        io_port = PORT_DATA; io_rd = 1'b1;
        @(negedge clk);
        io_rd = 1'b0;
        wait_idle("io_read");
        got = io_dout;
`endif
    endtask

    task automatic io_status_read(input bit vb, output logic [7:0] got);
        @(negedge clk);
        io_port = PORT_CTRL; io_rd = 1'b1; vblank = vb;
        #1 got = io_dout;
        @(negedge clk);
        io_rd = 1'b0; vblank = 1'b0;
        #1;
    endtask

    task automatic pulse_vblank();
        @(negedge clk);
        vblank = 1'b1; m_f = 1;
        @(negedge clk);
        vblank = 1'b0;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] got, exp;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        vectors++; if (cpu_wait !== 1'b0) begin miscompares++; $display("FAIL reset_cpu_wait: got %b required 0", cpu_wait); end
        vectors++; if (n_int !== 1'b1) begin miscompares++; $display("FAIL reset_n_int: got %b required 1", n_int); end
        vectors++; if (vram_we !== 1'b0) begin miscompares++; $display("FAIL reset_vram_we: got %b required 0", vram_we); end
        vectors++; if (vid_valid !== 1'b0) begin miscompares++; $display("FAIL reset_vid_valid: got %b required 0", vid_valid); end
        vectors++; if (vdp_regs !== 64'h0) begin miscompares++; $display("FAIL reset_regs: got %h required 0", vdp_regs); end
        vectors++; if (io_dout !== 8'h00) begin miscompares++; $display("FAIL reset_buffer: got %h required 00", io_dout); end
        vectors++; if (dbg_state !== ST_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d required IDLE", dbg_state); end
        exp = model_status_read(0);
        io_status_read(0, got);
        vectors++; if (got !== exp) begin miscompares++; $display("FAIL reset_status: got %h required %h", got, exp); end
    endtask

    task automatic test_addr_write();
        int w0;
        vid_rand = 1'b1;
        w0 = we_count;
        io_write(PORT_CTRL, 8'h00);
        io_write(PORT_CTRL, 8'h40);
        io_write(PORT_DATA, 8'hA5);
        io_write(PORT_DATA, 8'h5A);
        vectors++; if (mem[0] !== 8'hA5) begin miscompares++; $display("FAIL addr_write_0: got %h required a5", mem[0]); end
        vectors++; if (mem[1] !== 8'h5A) begin miscompares++; $display("FAIL addr_write_ptr1: got %h required 5a", mem[1]); end
        vectors++; if (we_count - w0 !== 2) begin miscompares++; $display("FAIL addr_write_count: got %0d required 2", we_count - w0); end
    endtask

    task automatic test_reg_write();
        int w0;
        w0 = we_count;
        io_write(PORT_CTRL, 8'hF0);
        io_write(PORT_CTRL, 8'h87);
        vectors++; if (vdp_regs[63:56] !== 8'hF0) begin miscompares++; $display("FAIL reg_write_r7: got %h required f0", vdp_regs[63:56]); end
        vectors++; if (we_count !== w0) begin miscompares++; $display("FAIL reg_write_no_vram: got %0d writes required 0", we_count - w0); end
        io_write(PORT_CTRL, 8'h55);
        io_write(PORT_CTRL, 8'h8F);
        vectors++; if (vdp_regs !== model_regs()) begin miscompares++; $display("FAIL reg_write_ignored: got %h required %h", vdp_regs, model_regs()); end
    endtask

    task automatic test_toggle_clear();
        io_write(PORT_CTRL, 8'h12);
        io_write(PORT_DATA, 8'h77);
        io_write(PORT_CTRL, 8'h34);
        io_write(PORT_CTRL, 8'h85);
        vectors++; if (vdp_regs !== model_regs()) begin miscompares++; $display("FAIL toggle_data_wr: got %h required %h", vdp_regs, model_regs()); end
        begin
            logic [7:0] got, exp;
            io_write(PORT_CTRL, 8'h99);
            exp = model_status_read(0);
            io_status_read(0, got);
            io_write(PORT_CTRL, 8'h56);
            io_write(PORT_CTRL, 8'h86);
            vectors++; if (vdp_regs[55:48] !== 8'h56) begin miscompares++; $display("FAIL toggle_status_rd: got %h required 56", vdp_regs[55:48]); end
        end
    endtask

    task automatic test_wrap();
        io_write(PORT_CTRL, 8'hFF);
        io_write(PORT_CTRL, 8'h7F);
        io_write(PORT_DATA, 8'h3C);
        io_write(PORT_DATA, 8'hC3);
        vectors++; if (mem[DEPTH-1] !== 8'h3C) begin miscompares++; $display("FAIL wrap_top: got %h required 3c", mem[DEPTH-1]); end
        vectors++; if (mem[0] !== 8'hC3) begin miscompares++; $display("FAIL wrap_zero: got %h required c3", mem[0]); end
    endtask

    task automatic test_starve();
        int n;
        logic [AW-1:0] a;
        vid_rand = 1'b0; vid_force = 1'b1;
        io_write(PORT_CTRL, 8'h34);
        io_write(PORT_CTRL, 8'h52);
        a = AW'(m_ptr);
        @(negedge clk);
        io_port = PORT_DATA; io_din = 8'h6B; io_wr = 1'b1;
        model_data_write(8'h6B);
        @(negedge clk);
        io_wr = 1'b0;
        #1;
        n = 0;
        while (vram_we !== 1'b1 && n < 50) begin
            if (cpu_wait === 1'b1) n++;
            @(negedge clk); #1;
        end
        vectors++; if (n !== SMAX) begin miscompares++; $display("FAIL starve_wait: got %0d pend cycles required %0d", n, SMAX); end
        vectors++; if (vram_addr !== a) begin miscompares++; $display("FAIL starve_addr: got %h required %h", vram_addr, a); end
        @(negedge clk); #1;
        vectors++; if (vid_valid !== 1'b0) begin miscompares++; $display("FAIL starve_vid_denied: got %b required 0", vid_valid); end
        @(negedge clk); #1;
        vectors++; if (vid_valid !== 1'b1) begin miscompares++; $display("FAIL starve_vid_resume: got %b required 1", vid_valid); end
        vid_force = 1'b0;
        wait_idle("starve");
        vectors++; if (mem[a] !== 8'h6B) begin miscompares++; $display("FAIL starve_data: got %h required 6b", mem[a]); end
    endtask

    task automatic test_irq();
        logic [7:0] got, exp;
        vid_rand = 1'b1;
        io_write(PORT_CTRL, 8'h20);
        io_write(PORT_CTRL, 8'h81);
        vectors++; if (n_int !== 1'b1) begin miscompares++; $display("FAIL irq_idle: got %b required 1", n_int); end
        pulse_vblank();
        vectors++; if (n_int !== 1'b0) begin miscompares++; $display("FAIL irq_assert: got %b required 0", n_int); end
        exp = model_status_read(0);
        io_status_read(0, got);
        vectors++; if (got !== exp) begin miscompares++; $display("FAIL irq_status: got %h required %h", got, exp); end
        vectors++; if (n_int !== 1'b1) begin miscompares++; $display("FAIL irq_cleared: got %b required 1", n_int); end
        exp = model_status_read(1);
        io_status_read(1, got);
        vectors++; if (got !== exp) begin miscompares++; $display("FAIL irq_coincident_status: got %h required %h", got, exp); end
        vectors++; if (n_int !== 1'b0) begin miscompares++; $display("FAIL irq_coincident_keep: got %b required 0", n_int); end
        exp = model_status_read(0);
        io_status_read(0, got);
        vectors++; if (got !== exp) begin miscompares++; $display("FAIL irq_coincident_f: got %h required %h", got, exp); end
        io_write(PORT_CTRL, 8'h00);
        io_write(PORT_CTRL, 8'h81);
        pulse_vblank();
        vectors++; if (n_int !== 1'b1) begin miscompares++; $display("FAIL irq_masked: got %b required 1", n_int); end
        exp = model_status_read(0);
        io_status_read(0, got);
        vectors++; if (got !== exp) begin miscompares++; $display("FAIL irq_masked_status: got %h required %h", got, exp); end
    endtask

    task automatic test_readback();
        logic [7:0] got, exp;
        mem[16'h0100] = 8'h11; shadow[16'h0100] = 8'h11;
        mem[16'h0101] = 8'h22; shadow[16'h0101] = 8'h22;
        io_write(PORT_CTRL, 8'h00);
        io_write(PORT_CTRL, 8'h01);
        exp = model_data_read();
        io_read_data(got);
        vectors++; if (got !== exp || got !== 8'h11) begin miscompares++; $display("FAIL readback_first: got %h required 11", got); end
        exp = model_data_read();
        io_read_data(got);
        vectors++; if (got !== exp || got !== 8'h22) begin miscompares++; $display("FAIL readback_second: got %h required 22", got); end
    endtask

    task automatic test_random();
        logic [7:0] got, exp, b1, b2;
        int a;
        vid_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    a  = $urandom_range(0, DEPTH - 1);
                    b1 = a[7:0];
                    b2 = {1'b0, 1'($urandom_range(0, 1)), a[13:8]};
                    io_write(PORT_CTRL, b1);
                    io_write(PORT_CTRL, b2);
                end
                1: io_write(PORT_DATA, 8'($urandom));
                2: begin
                    exp_q.push_back(model_data_read());
                    io_read_data(got);
                    exp = exp_q.pop_front();
                    vectors++;
                    if (got !== exp) begin miscompares++; $display("FAIL random_read_%0d: got %h required %h", i, got, exp); end
                end
                default: begin
                    b1 = 8'($urandom);
                    b2 = 8'h80 | 8'($urandom_range(0, 63));
                    io_write(PORT_CTRL, b1);
                    io_write(PORT_CTRL, b2);
                end
            endcase
        end
        vectors++; if (vdp_regs !== model_regs()) begin miscompares++; $display("FAIL random_regs: got %h required %h", vdp_regs, model_regs()); end
        while (wr_addr_q.size() > 0) begin
            logic [AW-1:0] wa;
            wa = wr_addr_q.pop_front();
            vectors++;
            if (mem[wa] !== shadow[wa]) begin miscompares++; $display("FAIL random_vram_%h: got %h required %h", wa, mem[wa], shadow[wa]); end
        end
    endtask

    task automatic test_reset_pend();
        int w0;
        vid_rand = 1'b0; vid_force = 1'b1;
        io_write(PORT_CTRL, 8'hAA);
        io_write(PORT_CTRL, 8'h6A);
        w0 = we_count;
        @(negedge clk);
        io_port = PORT_DATA; io_din = 8'hEE; io_wr = 1'b1;
        @(negedge clk);
        io_wr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0; vid_force = 1'b0;
        model_reset();
        repeat (12) @(negedge clk);
        #1;
        vectors++; if (we_count !== w0) begin miscompares++; $display("FAIL reset_pend_we: got %0d writes required 0", we_count - w0); end
        vectors++; if (mem[14'h2AAA] !== shadow[14'h2AAA]) begin miscompares++; $display("FAIL reset_pend_vram: got %h required %h", mem[14'h2AAA], shadow[14'h2AAA]); end
        vectors++; if (cpu_wait !== 1'b0) begin miscompares++; $display("FAIL reset_pend_wait: got %b required 0", cpu_wait); end
        vectors++; if (vdp_regs !== 64'h0) begin miscompares++; $display("FAIL reset_pend_regs: got %h required 0", vdp_regs); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            shadow[i] = 8'($urandom);
            mem[i] = shadow[i];
        end
        model_reset();
        test_reset();
        test_addr_write();
        test_reg_write();
        test_toggle_clear();
        test_wrap();
        test_starve();
        test_irq();
        test_readback();
        test_random();
        test_reset_pend();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vdp_port_ctrl.md
VDP_PORT_CTRL -- requirements
Module: vdp_port_ctrl

Interface
REQ-001 SHALL provide parameter VRAM_AW, default 14, VRAM address width.
REQ-002 SHALL provide parameter STARVE_MAX, default 8, the maximum number of cycles a pending CPU access may wait behind video requests.
REQ-003 clk  in  1  system clock; the only clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 io_wr / io_rd  in  1 each  single-cycle CPU I/O write/read strobes, already qualified by the I/O decode; never both high together.
REQ-006 io_port  in  1  0 = data port (0x98), 1 = control port (0x99).
REQ-007 io_din  in  8  CPU write data; io_dout  out  8  CPU read data.
REQ-008 cpu_wait  out  1  high while a data-port access is in flight; strobes are illegal while high.
REQ-009 vblank  in  1  single-cycle end-of-frame pulse; n_int  out  1  active-low interrupt.
REQ-010 vid_req  in  1  video fetch request; vid_addr  in  VRAM_AW  fetch address; vid_valid  out  1  vram_rdata holds video data this cycle.
REQ-011 vram_addr  out  VRAM_AW; vram_we  out  1; vram_wdata  out  8; vram_rdata  in  8, valid one cycle after the address is presented.
REQ-012 vdp_regs  out  64  registers R0..R7, with Rn in bits [8n+7:8n].

Function
REQ-013 SHALL implement a control-port two-byte latch: the first write stores the byte and sets the toggle; the second write clears the toggle.
REQ-014 On the second byte with bit7=0, SHALL load the address pointer with {byte2[5:0], byte1}, truncated to VRAM_AW; with bit6=0 it SHALL also issue a prefetch read.
REQ-015 On the second byte with bit7=1, SHALL write byte1 to R[byte2[2:0]]; byte2[5:3] ≠ 0 SHALL be ignored without a register write.
REQ-016 A data-port write SHALL clear the toggle, queue a VRAM write of io_din at the pointer, and post-increment the pointer, wrapping from 2^VRAM_AW-1 to 0.
REQ-017 A data-port read SHALL return the read-ahead buffer on io_dout in the same cycle, clear the toggle, post-increment the pointer, and queue a prefetch read.
REQ-018 A control-port read SHALL return the status {F,7'b0}, then clear F and the toggle.
REQ-019 vblank SHALL set F; n_int SHALL equal !(F & R1[5]). If vblank coincides with a status read, F SHALL remain set.
REQ-020 FSM states: IDLE -> PEND on a queued access; PEND -> ACC in the first cycle the CPU wins the VRAM port; ACC -> IDLE after one cycle. A prefetch loads the buffer from vram_rdata in ACC.
REQ-021 cpu_wait SHALL equal (state != IDLE).
REQ-022 Arbitration: video wins whenever vid_req=1, except when the starvation counter reaches STARVE_MAX; then the CPU SHALL win the next cycle regardless of vid_req.
REQ-023 The starvation counter SHALL count cycles spent in PEND and clear on entering ACC.
REQ-024 vid_valid SHALL be asserted exactly one cycle after each granted video cycle; a denied video cycle SHALL produce no vid_valid.
REQ-025 vram_we SHALL be high only in the grant cycle of a CPU write.

Reset
REQ-026 On reset, the pointer, toggle, F, all registers, the buffer and the counter SHALL be 0, state SHALL be IDLE, and cpu_wait=0, n_int=1, vram_we=0, vid_valid=0.
REQ-027 Reset during PEND or ACC SHALL abandon the access; no VRAM write occurs after reset.

Configuration
REQ-028 Macro VDP_READ_AHEAD_EN: when defined, reads behave per REQ-014 and REQ-017.
REQ-029 Without VDP_READ_AHEAD_EN, address setup SHALL issue no prefetch; a data-port read SHALL queue a read and hold cpu_wait until ACC, and io_dout SHALL present the fetched byte in the cycle cpu_wait falls.

Structure
REQ-030 A shared package vdp_pkg SHALL hold the port encodings, the FSM state enum, the status bit positions, and register index constants.
REQ-031 An arbitration sub-module, vdp_vram_arb (grant logic plus starvation counter), is natural; the FSM and registers stay in vdp_port_ctrl.

Verification
REQ-032 Control writes 0x00, then 0x40, then data write 0xA5 -> VRAM[0x0000]=0xA5, pointer=0x0001.
REQ-033 Control writes 0xF0, then 0x87 -> R7=0xF0, vdp_regs[63:56]=0xF0, no VRAM access.
REQ-034 Pointer at 0x3FFF, data write -> VRAM[0x3FFF] written, pointer wraps to 0x0000.
REQ-035 vid_req held high, CPU write pending -> CPU granted after exactly STARVE_MAX=8 PEND cycles; vid_valid absent in that cycle.
REQ-036 R1=0x20, vblank pulse -> n_int=0; status read returns 0x80 -> n_int=1 next cycle.
REQ-037 With VDP_READ_AHEAD_EN, VRAM[0x0100]=0x11 and [0x0101]=0x22, address setup 0x00/0x01, two reads -> 0x11 then 0x22.
